adc_scan_ctrl: RTL and testbench
================================

Name: adc_scan_ctrl

Overview:
- Sequencer that shares one 12-bit sensor ADC between up to N_CH analog sensor channels (current sensors, 180° position sensor).
- Drives the analog mux select, waits a settle time, captures ADC codes, optionally averages them, and presents one result per channel on a valid/ready stream.
- Sits between the ADC front end and the control/telemetry logic; runs either one scan per start or continuous scans.

Parameters:
- N_CH, 4, number of sensor channels (2..16)
- BITS, 12, ADC code width
- SETTLE_CYC, 4, clock cycles spent in SELECT after a mux change (≥1)
- AVG_LOG2, 2, log2 of samples averaged per channel (used only with ADC_SCAN_AVG_EN)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start_i  in  1  one-cycle request to begin a scan
- cont_i  in  1  continuous mode: restart scan automatically after last channel
- ch_en_i  in  N_CH  channel enable mask, latched at scan start
- adc_data_i  in  BITS  ADC digital code (0..4095)
- mux_sel_o  out  $clog2(N_CH)  analog mux channel select
- sample_o  out  1  high in every cycle adc_data_i is captured
- busy_o  out  1  high whenever not IDLE
- res_valid_o  out  1  result valid
- res_ready_i  in  1  consumer ready
- res_ch_o  out  $clog2(N_CH)  channel of current result
- res_data_o  out  BITS  result code
- scan_done_o  out  1  one-cycle pulse on handshake of last result of a scan

Behaviour:
- Reset values: mux_sel_o=0, sample_o=0, busy_o=0, res_valid_o=0, res_ch_o=0, res_data_o=0, scan_done_o=0; state IDLE; counters, accumulator and latched mask cleared. Reset mid-scan aborts immediately; no result is emitted.
- FSM states: IDLE, SELECT, SAMPLE, OUTPUT.
- IDLE:
  - start_i=1 with ch_en_i≠0: latch mask, set mux_sel_o to the lowest enabled channel, go to SELECT.
  - start_i with mask=0: ignored; stay IDLE, no scan_done_o.
- SELECT: hold mux_sel_o for exactly SETTLE_CYC cycles (counter), then go to SAMPLE.
- SAMPLE:
  - sample_o=1 for one cycle per sample, capturing adc_data_i at that edge; back-to-back samples with no re-settle.
  - After the last sample, load res_data_o/res_ch_o, set res_valid_o, go to OUTPUT.
- OUTPUT:
  - res_valid_o, res_data_o and res_ch_o are held stable until res_valid_o&res_ready_i (unbounded backpressure stall).
  - On handshake, if a higher enabled channel remains in the latched mask: set mux_sel_o to it and go to SELECT.
  - Otherwise pulse scan_done_o in the handshake cycle, then:
    - cont_i=1: re-latch ch_en_i and go to SELECT on the lowest enabled channel; if the new mask is 0, go to IDLE.
    - cont_i=0: go to IDLE.
- Latency (1 sample): start at cycle 0 → SELECT cycles 1..SETTLE_CYC → SAMPLE cycle SETTLE_CYC+1 → res_valid_o at SETTLE_CYC+2.
- Handshake-to-next-valid: SETTLE_CYC+2 cycles.
- start_i while busy_o=1 is ignored. ch_en_i changes mid-scan have no effect until the next latch.
- Disabled channels are skipped with zero cycles spent on them.
- Channel order is always ascending. The last enabled channel wraps to the lowest only via a new scan.

Optional Feature:
- Macro ADC_SCAN_AVG_EN.
- Defined: SAMPLE lasts 2^AVG_LOG2 cycles. Accumulator is BITS+AVG_LOG2 bits, cleared on SELECT entry. res_data_o = accumulator >> AVG_LOG2 (truncating); max 4095 cannot overflow.
- Undefined: one sample per channel; res_data_o = captured code; AVG_LOG2 is ignored and no accumulator is synthesized.

Decomposition:
- Package adc_pkg holds:
  - ADC_BITS=12 and ADC_MAX_CODE=4095
  - typedef adc_code_t (logic [11:0])
  - typedef enum scan_state_e {IDLE, SELECT, SAMPLE, OUTPUT}
- Sub-module adc_next_ch: combinational priority finder that returns the next enabled channel above the current one plus a "none" flag. It is used for the first-channel and next-channel lookups.

Test Plan:
- SETTLE_CYC=4, averaging off, ch_en=4'b0101, ch0=1000, ch2=4095, ready=1, start at cycle 0:
  - valid ch0/1000 at cycle 6
  - valid ch2/4095 at cycle 12
  - scan_done_o pulse at cycle 12, then IDLE
- Backpressure: hold ready=0 for 20 cycles on ch0 result → valid/data/ch stable, no sample_o pulses; release → ch2 valid 6 cycles after handshake.
- ADC_SCAN_AVG_EN, AVG_LOG2=2, codes 100,101,102,103 on ch1 → res_data_o=101; sample_o high 4 consecutive cycles.
- cont_i=1, ch_en=4'b1000, ch3 code 0 → repeated ch3 results every 6 cycles with scan_done_o each. Switch ch_en to 0 mid-scan → the current scan finishes, then IDLE.
- Edge cases:
  - start with ch_en=0 → busy_o stays 0.
  - start while busy → ignored, result sequence unchanged.
  - rst asserted in SAMPLE → next cycle all outputs at reset values and no result.

Source files
------------

// File: rtl/adc_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_pkg
// Brief    : Shared ADC code constants, code type and scan FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package adc_pkg;

    localparam int ADC_BITS     = 12;
    localparam int ADC_MAX_CODE = 4095;

    typedef logic [11:0] adc_code_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        SAMPLE = 2'd2,
        OUTPUT = 2'd3
    } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/adc_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_ctrl_if
// Brief    : Control, ADC front-end and result-stream signals of the scanner.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_scan_ctrl_if #(
    parameter int N_CH = 4,
    parameter int BITS = 12
);
    localparam int c_CH_W = $clog2(N_CH);

    logic              start_i;
    logic              cont_i;
    logic [N_CH-1:0]   ch_en_i;
    logic [BITS-1:0]   adc_data_i;
    logic [c_CH_W-1:0] mux_sel_o;
    logic              sample_o;
    logic              busy_o;
    logic              res_valid_o;
    logic              res_ready_i;
    logic [c_CH_W-1:0] res_ch_o;
    logic [BITS-1:0]   res_data_o;
    logic              scan_done_o;

    modport master (
        input  start_i, cont_i, ch_en_i, adc_data_i, res_ready_i,
        output mux_sel_o, sample_o, busy_o, res_valid_o, res_ch_o, res_data_o, scan_done_o
    );

    modport slave (
        output start_i, cont_i, ch_en_i, adc_data_i, res_ready_i,
        input  mux_sel_o, sample_o, busy_o, res_valid_o, res_ch_o, res_data_o, scan_done_o
    );
endinterface
`default_nettype wire

// File: rtl/adc_scan_ctrl_next_ch.sv
`default_nettype none
// ============================================================================
// Module   : adc_next_ch
// Brief    : Finds the lowest enabled channel above (or at, with i_incl) i_cur.
// Revision : 1.0 - initial release
// ============================================================================
module adc_next_ch #(
    parameter int N_CH = 4
) (
    input  wire logic [N_CH-1:0]         i_mask,
    input  wire logic [$clog2(N_CH)-1:0] i_cur,
    input  wire logic                    i_incl,
    output logic      [$clog2(N_CH)-1:0] o_next,
    output logic                         o_none
);
    localparam int c_CH_W = $clog2(N_CH);

    // Descending scan so the lowest qualifying channel is the last one written.
    always_comb begin
        o_next = '0;
        o_none = 1'b1;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_incl ? (i >= int'(i_cur)) : (i > int'(i_cur)))) begin
                o_next = c_CH_W'(i);
                o_none = 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adc_scan_ctrl
// Brief    : Shares one ADC across N_CH channels: select, settle, sample, emit.
//            Define ADC_SCAN_AVG_EN to average 2^AVG_LOG2 samples per channel.
// Revision : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl
    import adc_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int BITS       = ADC_BITS,
    parameter int SETTLE_CYC = 4,
    parameter int AVG_LOG2   = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    adc_scan_ctrl_if.master bus
);
    localparam int c_CH_W = $clog2(N_CH);
`ifdef ADC_SCAN_AVG_EN
    localparam int c_NS = 1 << AVG_LOG2;
`else
    localparam int c_NS = 1;
`endif
    localparam int c_CNT_MAX = (SETTLE_CYC > c_NS) ? SETTLE_CYC : c_NS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SAMPLE_LAST = c_CNT_W'(c_NS - 1);

    scan_state_e         r_state;
    scan_state_e         w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [N_CH-1:0]     r_mask;
    logic [c_CH_W-1:0]   r_mux_sel;
    logic [c_CH_W-1:0]   r_res_ch;
    logic [BITS-1:0]     r_res_data;
    logic [BITS-1:0]     w_result;

    logic [c_CH_W-1:0]   w_first_ch;
    logic                w_first_none;
    logic [c_CH_W-1:0]   w_next_ch;
    logic                w_next_none;
    logic                w_hs;

    adc_next_ch #(.N_CH(N_CH)) u_first (
        .i_mask (bus.ch_en_i),
        .i_cur  ('0),
        .i_incl (1'b1),
        .o_next (w_first_ch),
        .o_none (w_first_none)
    );

    adc_next_ch #(.N_CH(N_CH)) u_next (
        .i_mask (r_mask),
        .i_cur  (r_mux_sel),
        .i_incl (1'b0),
        .o_next (w_next_ch),
        .o_none (w_next_none)
    );

    assign w_hs = (r_state == OUTPUT) && bus.res_ready_i;

`ifdef ADC_SCAN_AVG_EN
    logic [BITS+AVG_LOG2-1:0] r_acc;
    logic [BITS+AVG_LOG2-1:0] w_acc_sum;

    assign w_acc_sum = r_acc + {{AVG_LOG2{1'b0}}, bus.adc_data_i};
    assign w_result  = w_acc_sum[AVG_LOG2 +: BITS];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_state == SELECT) begin
            r_acc <= '0;
        end else if (r_state == SAMPLE) begin
            r_acc <= w_acc_sum;
        end
    end
`else
    logic w_unused_avg;
    assign w_unused_avg = (AVG_LOG2 != 0);
    assign w_result     = bus.adc_data_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bus.sample_o    = 1'b0;
        bus.busy_o      = (r_state != IDLE);
        bus.res_valid_o = 1'b0;
        bus.scan_done_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start_i && !w_first_none) w_state_nxt = SELECT;
            end
            SELECT: begin
                if (r_cnt == c_SETTLE_LAST) w_state_nxt = SAMPLE;
            end
            SAMPLE: begin
                bus.sample_o = 1'b1;
                if (r_cnt == c_SAMPLE_LAST) w_state_nxt = OUTPUT;
            end
            OUTPUT: begin
                bus.res_valid_o = 1'b1;
                if (w_hs) begin
                    if (!w_next_none) begin
                        w_state_nxt = SELECT;
                    end else begin
                        bus.scan_done_o = 1'b1;
                        w_state_nxt = (bus.cont_i && !w_first_none) ? SELECT : IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: the counter restarts on every state change, so one counter
    // serves both the settle window and the sample burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_mask     <= '0;
            r_mux_sel  <= '0;
            r_res_ch   <= '0;
            r_res_data <= '0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == SELECT || r_state == SAMPLE) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == IDLE && bus.start_i && !w_first_none) begin
                r_mask    <= bus.ch_en_i;
                r_mux_sel <= w_first_ch;
            end else if (w_hs) begin
                if (!w_next_none) begin
                    r_mux_sel <= w_next_ch;
                end else if (bus.cont_i) begin
                    r_mask <= bus.ch_en_i;
                    if (!w_first_none) r_mux_sel <= w_first_ch;
                end
            end

            if (r_state == SAMPLE && r_cnt == c_SAMPLE_LAST) begin
                r_res_data <= w_result;
                r_res_ch   <= r_mux_sel;
            end
        end
    end

    assign bus.mux_sel_o  = r_mux_sel;
    assign bus.res_ch_o   = r_res_ch;
    assign bus.res_data_o = r_res_data;
endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_scan_ctrl
// Brief    : Directed self-checking bench for adc_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_scan_ctrl;
    localparam int c_SETTLE = 4;
`ifdef ADC_SCAN_AVG_EN
    localparam int c_NS = 4;
`else
    localparam int c_NS = 1;
`endif
    localparam int c_LAT = c_SETTLE + 1 + c_NS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    int   n;
    int   bad;
    int   cnt;
    int   hold_ch;
    int   hold_data;
    logic avg_mode = 1'b0;
    int   sidx = 0;
    logic [11:0] codes [4];

    adc_scan_ctrl_if #(.N_CH(4), .BITS(12)) bus ();

    adc_scan_ctrl #(
        .N_CH       (4),
        .BITS       (12),
        .SETTLE_CYC (c_SETTLE),
        .AVG_LOG2   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // ADC model: fixed code per channel, or a ramp indexed by sample count.
    always_comb begin
        if (avg_mode) bus.adc_data_i = 12'(100 + sidx);
        else          bus.adc_data_i = codes[bus.mux_sel_o];
    end

    always @(posedge clk) begin
        if (!avg_mode) sidx <= 0;
        else if (bus.sample_o) sidx <= sidx + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max, inout int cyc);
        while (!bus.res_valid_o && cyc < max) begin
            step();
            cyc++;
        end
    endtask

    task automatic start_scan(input logic [3:0] mask);
        bus.ch_en_i = mask;
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    initial begin
        codes[0] = 12'd1000;
        codes[1] = 12'd555;
        codes[2] = 12'd4095;
        codes[3] = 12'd0;
        bus.start_i     = 1'b0;
        bus.cont_i      = 1'b0;
        bus.ch_en_i     = 4'b0000;
        bus.res_ready_i = 1'b1;
        repeat (3) step();
        check("rst_valid", int'(bus.res_valid_o), 0);
        check("rst_busy",  int'(bus.busy_o), 0);
        check("rst_data",  int'(bus.res_data_o), 0);
        rst = 1'b0;
        step();

        // Two-channel scan with ready held high.
        start_scan(4'b0101);
        n = 1;
        wait_valid(40, n);
        check("t1_lat0", n, c_LAT);
        check("t1_ch0",  int'(bus.res_ch_o), 0);
        check("t1_d0",   int'(bus.res_data_o), 1000);
        check("t1_done0", int'(bus.scan_done_o), 0);
        step(); n++;
        wait_valid(80, n);
        check("t1_lat2", n, 2 * c_LAT);
        check("t1_ch2",  int'(bus.res_ch_o), 2);
        check("t1_d2",   int'(bus.res_data_o), 4095);
        check("t1_done", int'(bus.scan_done_o), 1);
        step();
        check("t1_idle", int'(bus.busy_o), 0);
        check("t1_done_pulse", int'(bus.scan_done_o), 0);

        // Backpressure on ch0 with an ignored start while busy.
        bus.res_ready_i = 1'b0;
        start_scan(4'b0101);
        n = 1;
        wait_valid(40, n);
        check("t2_lat", n, c_LAT);
        hold_ch   = int'(bus.res_ch_o);
        hold_data = int'(bus.res_data_o);
        bad = 0;
        bus.ch_en_i = 4'b1111;
        bus.start_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            bus.start_i = 1'b0;
            if (!bus.res_valid_o || bus.sample_o || int'(bus.res_ch_o) != hold_ch
                || int'(bus.res_data_o) != hold_data || bus.scan_done_o) bad++;
        end
        check("t2_stall", bad, 0);
        bus.res_ready_i = 1'b1;
        step(); n = 1;
        wait_valid(40, n);
        check("t2_hs_lat", n, c_LAT);
        check("t2_ch",     int'(bus.res_ch_o), 2);
        check("t2_done",   int'(bus.scan_done_o), 1);
        step();

        // Empty mask start is ignored.
        start_scan(4'b0000);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.busy_o || bus.scan_done_o) bad++;
            step();
        end
        check("t4_empty", bad, 0);

        // Reset while sampling aborts the scan.
        start_scan(4'b0010);
        n = 0;
        while (!bus.sample_o && n < 20) begin
            step();
            n++;
        end
        check("t5_in_sample", int'(bus.sample_o), 1);
        rst = 1'b1;
        step();
        check("t5_rst_valid", int'(bus.res_valid_o), 0);
        check("t5_rst_busy",  int'(bus.busy_o), 0);
        check("t5_rst_samp",  int'(bus.sample_o), 0);
        check("t5_rst_mux",   int'(bus.mux_sel_o), 0);
        check("t5_rst_ch",    int'(bus.res_ch_o), 0);
        check("t5_rst_data",  int'(bus.res_data_o), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.res_valid_o || bus.busy_o) bad++;
        end
        check("t5_no_result", bad, 0);

        // Continuous mode on ch3; mask cleared mid-scan ends after that scan.
        bus.cont_i = 1'b1;
        start_scan(4'b1000);
        n = 1;
        wait_valid(40, n);
        check("t3_lat0", n, c_LAT);
        check("t3_ch",   int'(bus.res_ch_o), 3);
        check("t3_d",    int'(bus.res_data_o), 0);
        check("t3_done0", int'(bus.scan_done_o), 1);
        step(); n++;
        wait_valid(80, n);
        check("t3_lat1", n, 2 * c_LAT);
        check("t3_done1", int'(bus.scan_done_o), 1);
        step(); n++;
        bus.ch_en_i = 4'b0000;
        wait_valid(120, n);
        check("t3_lat2", n, 3 * c_LAT);
        check("t3_done2", int'(bus.scan_done_o), 1);
        step();
        check("t3_idle", int'(bus.busy_o), 0);
        bus.cont_i = 1'b0;

`ifdef ADC_SCAN_AVG_EN
        // Averaging: ramp 100..103 on ch1 gives 101.
        avg_mode = 1'b1;
        step();
        start_scan(4'b0010);
        cnt = 0;
        n = 1;
        while (!bus.res_valid_o && n < 40) begin
            if (bus.sample_o) cnt++;
            step();
            n++;
        end
        check("avg_samples", cnt, 4);
        check("avg_lat",     n, c_LAT);
        check("avg_data",    int'(bus.res_data_o), 101);
        step();
        avg_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
